// File: rtl/rvh_l1d_refill_way_alloc.sv
// Refill way allocator for one L1D bank. Picks a free way or reserves and evicts a victim, then commits MESI.
// Victim policy: global round-robin by default, per-set tree-PLRU when L1D_REFILL_PLRU_EN is defined.
//
// state    | meaning
// IDLE     | ready for a refill request
// PEEK     | LST peek of the registered set, choose free way or victim
// RESERVE  | victim reservation via LST check handshake
// EVICT    | eviction request to the writeback path
// WAIT_ACK | waiting for the eviction completion pulse
// WRITE    | LST s0 MESI write and allocation completion
module rvh_l1d_refill_way_alloc #(
  parameter int SET_IDX_W = 6,
  parameter int WAY_NUM   = 4,
  parameter int WAY_IDX_W = $clog2(WAY_NUM)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   refill_req_valid,
  output logic                   refill_req_ready,
  input  logic [SET_IDX_W-1:0]   refill_req_set_idx,
  input  logic [1:0]             refill_req_mesi,
  output logic [SET_IDX_W-1:0]   lst_peek_set_idx,
  input  logic [WAY_NUM*2-1:0]   lst_peek_mesi_sta,
  input  logic [WAY_IDX_W-1:0]   lst_peek_avail_way,
  output logic                   lst_check_valid,
  input  logic                   lst_check_ready,
  output logic [SET_IDX_W-1:0]   lst_check_set_idx,
  output logic [WAY_IDX_W-1:0]   lst_check_way_idx,
  output logic                   evict_valid,
  input  logic                   evict_ready,
  output logic [SET_IDX_W-1:0]   evict_set_idx,
  output logic [WAY_IDX_W-1:0]   evict_way_idx,
  output logic                   evict_dirty,
  input  logic                   evict_done,
  output logic                   lst_wr_en,
  output logic [SET_IDX_W-1:0]   lst_wr_set_idx,
  output logic [WAY_IDX_W-1:0]   lst_wr_way_idx,
  output logic [1:0]             lst_wr_mesi,
  output logic                   alloc_done,
  output logic [WAY_IDX_W-1:0]   alloc_way_idx
);

  typedef enum logic [2:0] {
    S_IDLE, S_PEEK, S_RESERVE, S_EVICT, S_WAIT_ACK, S_WRITE
  } state_t;

  state_t                state;
  logic [SET_IDX_W-1:0]  set_q;
  logic [WAY_IDX_W-1:0]  way_q;
  logic [1:0]            mesi_q;
  logic                  peek_free;
  logic [1:0]            victim_mesi;
  logic [WAY_IDX_W-1:0]  victim_way;

  // All index/data outputs are the request registers; only the strobes are decoded.
  assign lst_peek_set_idx  = set_q;
  assign lst_check_set_idx = set_q;
  assign lst_check_way_idx = way_q;
  assign evict_set_idx     = set_q;
  assign evict_way_idx     = way_q;
  assign lst_wr_set_idx    = set_q;
  assign lst_wr_way_idx    = way_q;
  assign lst_wr_mesi       = mesi_q;
  assign alloc_way_idx     = way_q;

  always_comb begin
    peek_free   = 1'b0;
    victim_mesi = 2'd0;
    for (int i = 0; i < WAY_NUM; i++) begin
      if (lst_peek_mesi_sta[2*i +: 2] == 2'd0) peek_free = 1'b1;
      if (WAY_IDX_W'(i) == victim_way) victim_mesi = lst_peek_mesi_sta[2*i +: 2];
    end
  end

`ifdef L1D_REFILL_PLRU_EN
  localparam int SET_NUM = 1 << SET_IDX_W;

  logic [WAY_NUM-2:0] plru_q [SET_NUM];
  logic [WAY_NUM-2:0] plru_upd;

  // Heap-ordered tree: node n has children 2n+1 (bit 0, lower half) and 2n+2 (bit 1).
  always_comb begin
    logic [WAY_NUM-2:0] row;
    int node;
    row        = plru_q[set_q];
    node       = 0;
    victim_way = '0;
    for (int lvl = 0; lvl < WAY_IDX_W; lvl++) begin
      victim_way[WAY_IDX_W-1-lvl] = row[node];
      node = 2*node + 1 + int'(row[node]);
    end
  end

  always_comb begin
    int node;
    plru_upd = plru_q[set_q];
    node     = 0;
    for (int lvl = 0; lvl < WAY_IDX_W; lvl++) begin
      plru_upd[node] = ~way_q[WAY_IDX_W-1-lvl];
      node = 2*node + 1 + int'(way_q[WAY_IDX_W-1-lvl]);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int s = 0; s < SET_NUM; s++) plru_q[s] <= '0;
    end else if (state == S_WRITE) begin
      plru_q[set_q] <= plru_upd;
    end
  end
`else
  logic [WAY_IDX_W-1:0] rr_ptr;
  assign victim_way = rr_ptr;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state            <= S_IDLE;
      refill_req_ready <= 1'b1;
      set_q            <= '0;
      way_q            <= '0;
      mesi_q           <= '0;
      lst_check_valid  <= 1'b0;
      evict_valid      <= 1'b0;
      evict_dirty      <= 1'b0;
      lst_wr_en        <= 1'b0;
      alloc_done       <= 1'b0;
`ifndef L1D_REFILL_PLRU_EN
      rr_ptr           <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (refill_req_valid && refill_req_ready) begin
            set_q            <= refill_req_set_idx;
            mesi_q           <= refill_req_mesi;
            refill_req_ready <= 1'b0;
            state            <= S_PEEK;
          end
        end
        S_PEEK: begin
          if (peek_free) begin
            way_q       <= lst_peek_avail_way;
            evict_dirty <= 1'b0;
            lst_wr_en   <= 1'b1;
            alloc_done  <= 1'b1;
            state       <= S_WRITE;
          end else begin
            way_q           <= victim_way;
            evict_dirty     <= (victim_mesi == 2'd3);
            lst_check_valid <= 1'b1;
`ifndef L1D_REFILL_PLRU_EN
            rr_ptr          <= rr_ptr + WAY_IDX_W'(1);
`endif
            state           <= S_RESERVE;
          end
        end
        S_RESERVE: begin
          if (lst_check_ready) begin
            lst_check_valid <= 1'b0;
            evict_valid     <= 1'b1;
            state           <= S_EVICT;
          end
        end
        S_EVICT: begin
          if (evict_ready) begin
            evict_valid <= 1'b0;
            state       <= S_WAIT_ACK;
          end
        end
        S_WAIT_ACK: begin
          if (evict_done) begin
            lst_wr_en  <= 1'b1;
            alloc_done <= 1'b1;
            state      <= S_WRITE;
          end
        end
        S_WRITE: begin
          lst_wr_en        <= 1'b0;
          alloc_done       <= 1'b0;
          refill_req_ready <= 1'b1;
          state            <= S_IDLE;
        end
        default: begin
          refill_req_ready <= 1'b1;
          state            <= S_IDLE;
        end
      endcase
    end
  end

  // A refill must never install an INVALID line.
  a_req_mesi_valid: assert property (@(posedge clk) disable iff (!rstn)
    (refill_req_valid && refill_req_ready) |-> (refill_req_mesi != 2'd0));

endmodule

// File: tb/tb_rvh_l1d_refill_way_alloc.sv
// Directed bench for the refill way allocator; inputs driven and outputs sampled on the falling edge.
module tb_rvh_l1d_refill_way_alloc;
  localparam int SET_IDX_W = 6;
  localparam int WAY_NUM   = 4;
  localparam int WAY_IDX_W = 2;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic refill_req_valid = 1'b0;
  logic refill_req_ready;
  logic [SET_IDX_W-1:0] refill_req_set_idx = '0;
  logic [1:0] refill_req_mesi = 2'd1;
  logic [SET_IDX_W-1:0] lst_peek_set_idx;
  logic [WAY_NUM*2-1:0] lst_peek_mesi_sta = 8'h55;
  logic [WAY_IDX_W-1:0] lst_peek_avail_way = '0;
  logic lst_check_valid;
  logic lst_check_ready = 1'b0;
  logic [SET_IDX_W-1:0] lst_check_set_idx;
  logic [WAY_IDX_W-1:0] lst_check_way_idx;
  logic evict_valid;
  logic evict_ready = 1'b0;
  logic [SET_IDX_W-1:0] evict_set_idx;
  logic [WAY_IDX_W-1:0] evict_way_idx;
  logic evict_dirty;
  logic evict_done = 1'b0;
  logic lst_wr_en;
  logic [SET_IDX_W-1:0] lst_wr_set_idx;
  logic [WAY_IDX_W-1:0] lst_wr_way_idx;
  logic [1:0] lst_wr_mesi;
  logic alloc_done;
  logic [WAY_IDX_W-1:0] alloc_way_idx;

  int checks = 0;
  int failures = 0;

`ifdef L1D_REFILL_PLRU_EN
  // Every pre-reset test uses a fresh set, so the tree points at way 0 each time.
  logic [1:0] exp_single [4] = '{2'd0, 2'd0, 2'd0, 2'd0};
  logic [1:0] exp_b2b    [5] = '{2'd0, 2'd2, 2'd1, 2'd3, 2'd0};
`else
  logic [1:0] exp_single [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
  logic [1:0] exp_b2b    [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`endif

  always #5 clk = ~clk;

  rvh_l1d_refill_way_alloc #(
    .SET_IDX_W(SET_IDX_W), .WAY_NUM(WAY_NUM), .WAY_IDX_W(WAY_IDX_W)
  ) dut (
    .clk(clk), .rstn(rstn),
    .refill_req_valid(refill_req_valid), .refill_req_ready(refill_req_ready),
    .refill_req_set_idx(refill_req_set_idx), .refill_req_mesi(refill_req_mesi),
    .lst_peek_set_idx(lst_peek_set_idx), .lst_peek_mesi_sta(lst_peek_mesi_sta),
    .lst_peek_avail_way(lst_peek_avail_way),
    .lst_check_valid(lst_check_valid), .lst_check_ready(lst_check_ready),
    .lst_check_set_idx(lst_check_set_idx), .lst_check_way_idx(lst_check_way_idx),
    .evict_valid(evict_valid), .evict_ready(evict_ready),
    .evict_set_idx(evict_set_idx), .evict_way_idx(evict_way_idx),
    .evict_dirty(evict_dirty), .evict_done(evict_done),
    .lst_wr_en(lst_wr_en), .lst_wr_set_idx(lst_wr_set_idx),
    .lst_wr_way_idx(lst_wr_way_idx), .lst_wr_mesi(lst_wr_mesi),
    .alloc_done(alloc_done), .alloc_way_idx(alloc_way_idx)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  // Issues a request and leaves the DUT in PEEK at the returned negedge.
  task automatic send_req(input logic [SET_IDX_W-1:0] s, input logic [1:0] m);
    refill_req_set_idx = s;
    refill_req_mesi = m;
    refill_req_valid = 1'b1;
    tick();
    refill_req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    tick(); tick();
    checks++; if (refill_req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", refill_req_ready); end
    checks++; if ({lst_check_valid, evict_valid, evict_dirty, lst_wr_en, alloc_done} !== 5'b0) begin failures++;
      $display("FAIL reset_strobes got=%b exp=00000", {lst_check_valid, evict_valid, evict_dirty, lst_wr_en, alloc_done}); end
    checks++; if ({lst_peek_set_idx, alloc_way_idx, lst_wr_mesi} !== '0) begin failures++;
      $display("FAIL reset_fields got=%h exp=0", {lst_peek_set_idx, alloc_way_idx, lst_wr_mesi}); end
    rstn = 1'b1;
    tick();
    checks++; if (refill_req_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%b exp=1", refill_req_ready); end
  endtask

  task automatic test_free_way();
    bit saw_check = 0, saw_evict = 0;
    lst_peek_mesi_sta = 8'h87;  // way3=E way2=I way1=S way0=M
    lst_peek_avail_way = 2'd2;
    send_req(6'd5, 2'd2);
    saw_check |= lst_check_valid; saw_evict |= evict_valid;
    checks++; if (refill_req_ready !== 1'b0) begin failures++; $display("FAIL free_busy_ready got=%b exp=0", refill_req_ready); end
    checks++; if (lst_peek_set_idx !== 6'd5) begin failures++; $display("FAIL free_peek_set got=%0d exp=5", lst_peek_set_idx); end
    checks++; if (lst_wr_en !== 1'b0) begin failures++; $display("FAIL free_wr_early got=%b exp=0", lst_wr_en); end
    tick();
    saw_check |= lst_check_valid; saw_evict |= evict_valid;
    checks++; if ({lst_wr_en, alloc_done} !== 2'b11) begin failures++; $display("FAIL free_wr_en got=%b exp=11", {lst_wr_en, alloc_done}); end
    checks++; if (lst_wr_set_idx !== 6'd5 || lst_wr_way_idx !== 2'd2 || lst_wr_mesi !== 2'd2) begin failures++;
      $display("FAIL free_wr_fields got=set%0d way%0d mesi%0d exp=set5 way2 mesi2", lst_wr_set_idx, lst_wr_way_idx, lst_wr_mesi); end
    checks++; if (alloc_way_idx !== 2'd2) begin failures++; $display("FAIL free_alloc_way got=%0d exp=2", alloc_way_idx); end
    tick();
    saw_check |= lst_check_valid; saw_evict |= evict_valid;
    checks++; if ({saw_check, saw_evict} !== 2'b00) begin failures++; $display("FAIL free_no_evict got=%b exp=00", {saw_check, saw_evict}); end
    checks++; if ({refill_req_ready, lst_wr_en, alloc_done} !== 3'b100) begin failures++;
      $display("FAIL free_back_idle got=%b exp=100", {refill_req_ready, lst_wr_en, alloc_done}); end
    lst_peek_avail_way = 2'd0;
  endtask

  task automatic test_full_clean();
    lst_peek_mesi_sta = 8'h55;
    send_req(6'd9, 2'd1);
    tick();
    checks++; if (lst_check_valid !== 1'b1 || lst_check_way_idx !== exp_single[0] || lst_check_set_idx !== 6'd9) begin failures++;
      $display("FAIL clean_check got=v%b way%0d set%0d exp=v1 way%0d set9", lst_check_valid, lst_check_way_idx, lst_check_set_idx, exp_single[0]); end
    checks++; if (evict_dirty !== 1'b0) begin failures++; $display("FAIL clean_dirty got=%b exp=0", evict_dirty); end
    lst_check_ready = 1'b1; tick(); lst_check_ready = 1'b0;
    checks++; if ({lst_check_valid, evict_valid} !== 2'b01 || evict_way_idx !== exp_single[0] || evict_set_idx !== 6'd9) begin failures++;
      $display("FAIL clean_evict got=cv%b ev%b way%0d set%0d", lst_check_valid, evict_valid, evict_way_idx, evict_set_idx); end
    evict_ready = 1'b1; tick(); evict_ready = 1'b0;
    checks++; if ({evict_valid, lst_wr_en} !== 2'b00) begin failures++; $display("FAIL clean_wait got=%b exp=00", {evict_valid, lst_wr_en}); end
    evict_done = 1'b1; tick(); evict_done = 1'b0;
    checks++; if (lst_wr_en !== 1'b1 || lst_wr_way_idx !== exp_single[0] || lst_wr_mesi !== 2'd1 || alloc_done !== 1'b1) begin failures++;
      $display("FAIL clean_write got=en%b way%0d mesi%0d done%b", lst_wr_en, lst_wr_way_idx, lst_wr_mesi, alloc_done); end
    tick();
  endtask

  task automatic test_stalled();
    int stable_bad = 0;
    lst_peek_mesi_sta = 8'h55;
    send_req(6'd12, 2'd2);
    tick();
    for (int i = 0; i < 4; i++) begin
      if (lst_check_valid !== 1'b1 || lst_check_way_idx !== exp_single[1] || lst_check_set_idx !== 6'd12 || evict_valid !== 1'b0) stable_bad++;
      tick();
    end
    checks++; if (stable_bad != 0) begin failures++; $display("FAIL stall_check_stable got=%0d bad cycles exp=0", stable_bad); end
    lst_check_ready = 1'b1; tick(); lst_check_ready = 1'b0;
    stable_bad = 0;
    for (int i = 0; i < 3; i++) begin
      if (evict_valid !== 1'b1 || lst_check_valid !== 1'b0 || evict_way_idx !== exp_single[1] || evict_set_idx !== 6'd12) stable_bad++;
      tick();
    end
    checks++; if (stable_bad != 0) begin failures++; $display("FAIL stall_evict_stable got=%0d bad cycles exp=0", stable_bad); end
    evict_ready = 1'b1; tick(); evict_ready = 1'b0;
    stable_bad = 0;
    for (int i = 0; i < 2; i++) begin
      if (evict_valid !== 1'b0 || lst_check_valid !== 1'b0 || lst_wr_en !== 1'b0) stable_bad++;
      tick();
    end
    checks++; if (stable_bad != 0) begin failures++; $display("FAIL stall_single_req got=%0d bad cycles exp=0", stable_bad); end
    evict_done = 1'b1; tick(); evict_done = 1'b0;
    checks++; if (lst_wr_en !== 1'b1 || lst_wr_way_idx !== exp_single[1] || lst_wr_set_idx !== 6'd12) begin failures++;
      $display("FAIL stall_write got=en%b way%0d set%0d exp=en1 way%0d set12", lst_wr_en, lst_wr_way_idx, lst_wr_set_idx, exp_single[1]); end
    tick();
  endtask

  task automatic test_dirty_stray();
    lst_peek_mesi_sta = 8'hFF;
    send_req(6'd20, 2'd3);
    tick();
    checks++; if (evict_dirty !== 1'b1) begin failures++; $display("FAIL dirty_flag got=%b exp=1", evict_dirty); end
    evict_done = 1'b1; tick(); evict_done = 1'b0;
    checks++; if (lst_check_valid !== 1'b1 || lst_wr_en !== 1'b0) begin failures++;
      $display("FAIL dirty_stray got=cv%b wr%b exp=cv1 wr0", lst_check_valid, lst_wr_en); end
    lst_check_ready = 1'b1; tick(); lst_check_ready = 1'b0;
    checks++; if (evict_valid !== 1'b1 || evict_dirty !== 1'b1 || evict_way_idx !== exp_single[2]) begin failures++;
      $display("FAIL dirty_evict got=ev%b d%b way%0d exp=ev1 d1 way%0d", evict_valid, evict_dirty, evict_way_idx, exp_single[2]); end
    evict_ready = 1'b1; tick(); evict_ready = 1'b0;
    tick(); tick();
    checks++; if (lst_wr_en !== 1'b0) begin failures++; $display("FAIL dirty_wait_no_write got=%b exp=0", lst_wr_en); end
    evict_done = 1'b1; tick(); evict_done = 1'b0;
    checks++; if (lst_wr_en !== 1'b1 || lst_wr_way_idx !== exp_single[2] || lst_wr_mesi !== 2'd3) begin failures++;
      $display("FAIL dirty_write got=en%b way%0d mesi%0d", lst_wr_en, lst_wr_way_idx, lst_wr_mesi); end
    tick();
    lst_peek_mesi_sta = 8'h55;
  endtask

  task automatic test_reset_wait_ack();
    send_req(6'd30, 2'd1);
    tick();
    checks++; if (lst_check_way_idx !== exp_single[3]) begin failures++;
      $display("FAIL rst_victim got=%0d exp=%0d", lst_check_way_idx, exp_single[3]); end
    lst_check_ready = 1'b1; tick(); lst_check_ready = 1'b0;
    evict_ready = 1'b1; tick(); evict_ready = 1'b0;
    checks++; if ({refill_req_ready, evict_valid} !== 2'b00) begin failures++; $display("FAIL rst_in_wait got=%b exp=00", {refill_req_ready, evict_valid}); end
    #2 rstn = 1'b0;
    #1;
    checks++; if (refill_req_ready !== 1'b1 || {lst_check_valid, evict_valid, lst_wr_en, alloc_done} !== 4'b0) begin failures++;
      $display("FAIL rst_async got=rdy%b strobes%b exp=rdy1 strobes0000", refill_req_ready, {lst_check_valid, evict_valid, lst_wr_en, alloc_done}); end
    checks++; if ({lst_peek_set_idx, alloc_way_idx} !== '0) begin failures++;
      $display("FAIL rst_async_fields got=%h exp=0", {lst_peek_set_idx, alloc_way_idx}); end
    tick();
    rstn = 1'b1;
    evict_done = 1'b1; tick(); evict_done = 1'b0;
    tick();
    checks++; if (refill_req_ready !== 1'b1 || lst_wr_en !== 1'b0) begin failures++;
      $display("FAIL rst_release got=rdy%b wr%b exp=rdy1 wr0", refill_req_ready, lst_wr_en); end
  endtask

  task automatic test_back_to_back();
    lst_peek_mesi_sta = 8'h55;
    for (int k = 0; k < 5; k++) begin
      send_req(6'd3, 2'd2);
      tick();
      checks++; if (lst_check_valid !== 1'b1 || lst_check_way_idx !== exp_b2b[k]) begin failures++;
        $display("FAIL b2b_victim[%0d] got=v%b way%0d exp=v1 way%0d", k, lst_check_valid, lst_check_way_idx, exp_b2b[k]); end
      lst_check_ready = 1'b1; tick(); lst_check_ready = 1'b0;
      evict_ready = 1'b1; tick(); evict_ready = 1'b0;
      evict_done = 1'b1; tick(); evict_done = 1'b0;
      checks++; if (alloc_done !== 1'b1 || alloc_way_idx !== exp_b2b[k]) begin failures++;
        $display("FAIL b2b_alloc[%0d] got=d%b way%0d exp=d1 way%0d", k, alloc_done, alloc_way_idx, exp_b2b[k]); end
      tick();
      checks++; if (refill_req_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready[%0d] got=%b exp=1", k, refill_req_ready); end
    end
  endtask

  initial begin
    test_reset();
    test_free_way();
    test_full_clean();
    test_stalled();
    test_dirty_stray();
    test_reset_wait_ack();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rvh_l1d_refill_way_alloc.md
# rvh_l1d_refill_way_alloc

Refill way allocator for one L1D bank: takes a line-fill request from the miss/line-fill buffer and picks a destination way from the line-state table (LST) peek port. A free (INVALID) way is used directly. Otherwise it picks a victim, reserves it through the LST check handshake, and hands it to the eviction/writeback path. It then commits the new MESI state through the LST s0 write port, which also clears the reservation. The block sits directly upstream of the LST and is its only driver of the check and s0-write ports.

## Interface
- SET_IDX_W, 6: set index width (equals L1D_BANK_SET_INDEX_WIDTH)
- WAY_NUM, 4: ways per set; power of two, ≥2
- WAY_IDX_W, $clog2(WAY_NUM): way index width

- clk  in  1  clock; single clock domain
- rstn  in  1  reset, asynchronous, active-low
- refill_req_valid / refill_req_ready  in/out  1  request handshake
- refill_req_set_idx  in  SET_IDX_W  target set
- refill_req_mesi  in  2  final state of the new line (never INVALID)
- lst_peek_set_idx  out  SET_IDX_W  LST peek index
- lst_peek_mesi_sta  in  WAY_NUM*2  per-way MESI of the peeked set (combinational)
- lst_peek_avail_way  in  WAY_IDX_W  highest-index INVALID way; 0 if none
- lst_check_valid / lst_check_ready  out/in  1  victim reservation handshake
- lst_check_set_idx, lst_check_way_idx  out  SET_IDX_W, WAY_IDX_W  victim location
- evict_valid / evict_ready  out/in  1  eviction request handshake
- evict_set_idx, evict_way_idx  out  SET_IDX_W, WAY_IDX_W  victim location
- evict_dirty  out  1  victim was MODIFIED
- evict_done  in  1  one-cycle pulse: victim written back or dropped
- lst_wr_en  out  1  LST s0 MESI write strobe
- lst_wr_set_idx, lst_wr_way_idx, lst_wr_mesi  out  SET_IDX_W, WAY_IDX_W, 2  write target and data
- alloc_done  out  1  one-cycle completion pulse
- alloc_way_idx  out  WAY_IDX_W  allocated way; valid with alloc_done

## Operation
- MESI encoding: INVALID=0, SHARED=1, EXCLUSIVE=2, MODIFIED=3.
- FSM states: IDLE, PEEK, RESERVE, EVICT, WAIT_ACK, WRITE.
- **IDLE**
  - refill_req_ready=1.
  - On valid&ready, register set_idx and mesi, then go to PEEK.
- **PEEK**
  - lst_peek_set_idx = registered set.
  - free = OR over ways of (mesi==INVALID).
  - If free: way = lst_peek_avail_way, go to WRITE.
  - Otherwise: way = victim selector output; latch evict_dirty = (victim mesi==MODIFIED); go to RESERVE.
- **RESERVE**
  - lst_check_valid=1 with registered set/way.
  - On lst_check_ready=1 in the same cycle, go to EVICT. The reservation is taken on that edge.
  - While ready=0, valid and indices hold stable.
- **EVICT**
  - evict_valid=1.
  - On evict_ready, go to WAIT_ACK.
  - Payload holds until then.
- **WAIT_ACK**
  - Wait for evict_done, then go to WRITE.
  - evict_done in any other state is ignored.
- **WRITE**
  - lst_wr_en=1 with registered set/way/mesi.
  - alloc_done=1, alloc_way_idx=way.
  - Go to IDLE.
- A snoop invalidation of the reserved victim during EVICT/WAIT_ACK does not change the flow; WRITE still occurs.
- Victim selector without the configuration macro:
  - Global round-robin pointer, WAY_IDX_W bits.
  - Victim = pointer; pointer increments (wrapping WAY_NUM-1→0) on the PEEK→RESERVE transition only.
- Every output is a registered FSM decode or a registered field; no combinational input→output paths.
- An INVALID refill_req_mesi is a requester protocol violation. It is flagged by an assertion; behaviour in that case is undefined.

## Timing
- Reset values:
  - State IDLE; refill_req_ready=1.
  - All other outputs 0; round-robin pointer 0; PLRU bits 0.
- Reset mid-operation aborts immediately. Any LST reservation already taken is not cleared by this block.
- Free-way latency: accept at edge T; PEEK in cycle T+1; WRITE and alloc_done in cycle T+2. Next request can be accepted in cycle T+3.
- Eviction latency: 2 + (cycles to check_ready) + (cycles to evict_ready) + (cycles to evict_done) + 1.
- One request in flight at a time; refill_req_ready=0 outside IDLE.

## Configuration
- L1D_REFILL_PLRU_EN defined:
  - Victim comes from per-set tree-PLRU: 2^SET_IDX_W × (WAY_NUM-1) flops.
  - PLRU bits are updated toward "away from way" for the allocated set/way on every WRITE, including free-way allocations.
  - The round-robin pointer is removed.
- L1D_REFILL_PLRU_EN undefined: global round-robin as in Operation.

## Test plan
- Free way:
  - Stimulus: set 5, peek ways {M,S,I,E}, avail_way=2, mesi=E.
  - Required: lst_wr_en in cycle T+2 with set=5, way=2, mesi=2; alloc_done; no lst_check_valid or evict_valid.
- Full set, clean victim (round-robin):
  - Stimulus: all ways S, pointer 0.
  - Required: check way 0; evict_dirty=0; after evict_done, write way 0; pointer=1.
- Stalled handshakes:
  - Stimulus: lst_check_ready held 0 for 4 cycles, evict_ready held 0 for 3 cycles.
  - Required: indices stable throughout; exactly one reservation and one eviction request.
- Dirty victim with stray ack:
  - Stimulus: victim M; a stray evict_done pulse arrives during RESERVE.
  - Required: evict_dirty=1; stray pulse ignored; WRITE only after a genuine evict_done pulse in WAIT_ACK.
- Back-to-back full sets:
  - Stimulus: 5 back-to-back full-set requests.
  - Required: victims 0,1,2,3,0 (pointer wrap); PLRU build: victims 0,2,1,3,0 from reset.
- Reset in WAIT_ACK:
  - Stimulus: rstn low while in WAIT_ACK.
  - Required: outputs return to reset values asynchronously; refill_req_ready=1 after release.
